dram_responder: RTL

DRAM_RESPONDER -- requirements
Module: dram_responder

---
 rtl/dram_responder.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/dram_responder.sv
// dram_responder: single-outstanding AXI-like memory responder backed by a
// DEPTH x 64-bit register array. One read or write is in flight at a time,
// and each response is delayed by a programmable wait.
//
// state   | meaning
// --------+---------------------------------------------------------
// IDLE    | ready to accept a read or write address (read wins)
// RD_WAIT | read accepted, counting down the response latency
// RD_RESP | read data presented, waiting for R_READY
// WR_DATA | write address accepted, waiting for write data
// WR_WAIT | write data accepted, counting down the response latency
// WR_RESP | write response presented, waiting for B_READY
module dram_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        AR_VALID,
    input  logic [16:0] AR_ADDR,
    output logic        AR_READY,
    output logic        R_VALID,
    output logic [63:0] R_DATA,
    output logic [1:0]  R_RESP,
    input  logic        R_READY,
    input  logic        AW_VALID,
    input  logic [16:0] AW_ADDR,
    output logic        AW_READY,
    input  logic        W_VALID,
    input  logic [63:0] W_DATA,
    output logic        W_READY,
    output logic        B_VALID,
    output logic [1:0]  B_RESP,
    input  logic        B_READY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        RD_RESP = 3'd2,
        WR_DATA = 3'd3,
        WR_WAIT = 3'd4,
        WR_RESP = 3'd5
    } state_t;

    localparam logic [3:0] LAT_LOAD  = 4'(LATENCY);
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [16:0] addr_q, addr_d;
    logic [63:0] r_data_q, r_data_d;
    logic [63:0] mem_q [DEPTH];
    logic        mem_we;
    logic        addr_ok;
    logic [7:0]  word_idx;

    // Address lies in the memory window, is word aligned and inside the array.
    function automatic logic addr_legal(input logic [16:0] a);
        return a[16] && (a[15:11] == 5'd0) && (a[2:0] == 3'd0) &&
               ({24'd0, a[10:3]} < 32'(DEPTH));
    endfunction

    assign addr_ok  = addr_legal(addr_q);
    assign word_idx = addr_q[10:3];

    // State, wait counter, captured address and read data register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            addr_q   <= 17'd0;
            r_data_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            r_data_q <= r_data_d;
        end
    end

    // Memory array: cleared by reset so no data survives it, written on W handshake.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 64'd0;
            end
        end else if (mem_we) begin
            mem_q[word_idx] <= W_DATA;
        end
    end

    // Next-state, handshake outputs and response payloads.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        r_data_d = r_data_q;
        mem_we   = 1'b0;
        AR_READY = 1'b0;
        AW_READY = 1'b0;
        W_READY  = 1'b0;
        R_VALID  = 1'b0;
        R_DATA   = 64'd0;
        R_RESP   = RESP_OKAY;
        B_VALID  = 1'b0;
        B_RESP   = RESP_OKAY;

        case (state_q)
            IDLE: begin
                AR_READY = 1'b1;
                AW_READY = !AR_VALID;
                if (AR_VALID) begin
                    state_d = RD_WAIT;
                    addr_d  = AR_ADDR;
                    cnt_d   = LAT_LOAD;
                end else if (AW_VALID) begin
                    state_d = WR_DATA;
                    addr_d  = AW_ADDR;
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d  = RD_RESP;
                    r_data_d = addr_ok ? mem_q[word_idx] : 64'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_RESP: begin
                R_VALID = 1'b1;
                R_DATA  = r_data_q;
                R_RESP  = addr_ok ? RESP_OKAY : RESP_ERR;
                if (R_READY) begin
                    state_d  = IDLE;
                    r_data_d = 64'd0;
                end
            end
            WR_DATA: begin
                W_READY = 1'b1;
                if (W_VALID) begin
                    mem_we  = addr_ok;
                    state_d = WR_WAIT;
                    cnt_d   = LAT_LOAD;
                end
            end
            WR_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = WR_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_RESP: begin
                B_VALID = 1'b1;
                B_RESP  = addr_ok ? RESP_OKAY : RESP_ERR;
                if (B_READY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Nothing is offered or accepted while reset is asserted.
        if (!rst_n) begin
            mem_we   = 1'b0;
            AR_READY = 1'b0;
            AW_READY = 1'b0;
            W_READY  = 1'b0;
            R_VALID  = 1'b0;
            R_DATA   = 64'd0;
            R_RESP   = RESP_OKAY;
            B_VALID  = 1'b0;
            B_RESP   = RESP_OKAY;
        end
    end

endmodule
